wshb_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave pipelined Wishbone arbiter on the `sys_clk` domain. It is the successor of the fixed two-master VGA/mire interconnect in front of the SDRAM controller. It adds:
- round-robin fairness across any number of masters;
- a per-grant acknowledge quota that forces hand-over under contention;
- a cap on outstanding requests.

Masters see standard cyc/stb/stall/ack semantics. A master that loses the bus is stalled, never aborted.

---
 rtl/wshb_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wshb_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter.
// Round-robin grant, per-tenure ack quota, outstanding cap.
module wshb_rr_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int QUOTA      = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic                                       sys_clk,
  input  logic                                       sys_rst,
  input  logic [N_MASTERS-1:0]                       m_cyc,
  input  logic [N_MASTERS-1:0]                       m_stb,
  input  logic [N_MASTERS-1:0]                       m_we,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]       m_adr,
  input  logic [N_MASTERS-1:0][8*DATA_BYTES-1:0]     m_dat_w,
  input  logic [N_MASTERS-1:0][DATA_BYTES-1:0]       m_sel,
  output logic [N_MASTERS-1:0]                       m_ack,
  output logic [N_MASTERS-1:0]                       m_stall,
  output logic [8*DATA_BYTES-1:0]                    m_dat_r,
  output logic                                       s_cyc,
  output logic                                       s_stb,
  output logic                                       s_we,
  output logic [ADDR_WIDTH-1:0]                      s_adr,
  output logic [8*DATA_BYTES-1:0]                    s_dat_w,
  output logic [DATA_BYTES-1:0]                      s_sel,
  input  logic                                       s_ack,
  input  logic                                       s_stall,
  input  logic [8*DATA_BYTES-1:0]                    s_dat_r,
  output logic [$clog2(N_MASTERS)-1:0]               gnt_idx,
  output logic                                       busy
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t               state;
  state_t               nstate;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        cand;
  logic                 any_req;
  logic [OW-1:0]        outst;
  logic [OW-1:0]        outst_nxt;
  logic [QW-1:0]        qcnt;
  logic                 qcnt_full;
  logic                 quota_hit;
  logic                 hold;
  logic                 accept;
  logic                 contend;
  logic [N_MASTERS-1:0] gnt_oh;

  assign gnt_oh    = N_MASTERS'(1) << gnt_idx;
  assign contend   = |(m_cyc & ~gnt_oh);
  assign hold      = (outst == OW'(MAX_OUTST));
  assign accept    = s_stb & ~s_stall;
  assign qcnt_full = (qcnt == QW'(QUOTA));
  assign quota_hit = (QUOTA != 0) && qcnt_full;
  assign busy      = (state != IDLE);
  assign m_dat_r   = s_dat_r;

  // Slave-side mux follows only the registered grant.
  assign s_we    = m_we[gnt_idx];
  assign s_adr   = m_adr[gnt_idx];
  assign s_dat_w = m_dat_w[gnt_idx];
  assign s_sel   = m_sel[gnt_idx];

  // Round-robin scan: nearest requester after ptr wins.
  always_comb begin
    pick    = ptr;
    cand    = ptr;
    any_req = 1'b0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % N_MASTERS);
      if (m_cyc[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  // Outstanding count: accepts up, acks down.
  always_comb begin
    outst_nxt = outst;
    if (accept && !s_ack) begin
      outst_nxt = outst + OW'(1);
    end else if (!accept && s_ack && outst != '0) begin
      outst_nxt = outst - OW'(1);
    end
  end

  // State register; reset drops the bus at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state selection.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (any_req) nstate = OWN;
      end
      OWN: begin
        if (!m_cyc[gnt_idx]) begin
          nstate = IDLE;
        end else if (quota_hit && contend) begin
          nstate = DRAIN;
        end
      end
      DRAIN: begin
        if (outst == '0 || !m_cyc[gnt_idx]) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Bus control and per-master stall/ack steering.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_stall = '1;
    m_ack   = '0;
    unique case (state)
      IDLE: begin
        s_cyc = 1'b0;
      end
      OWN: begin
        s_cyc            = m_cyc[gnt_idx];
        s_stb            = m_stb[gnt_idx] & ~hold;
        m_stall[gnt_idx] = s_stall | hold;
        m_ack[gnt_idx]   = s_ack;
      end
      DRAIN: begin
        s_cyc          = 1'b1;
        m_ack[gnt_idx] = s_ack;
      end
      default: begin
        s_cyc = 1'b0;
      end
    endcase
  end

  // Grant, pointer, outstanding and quota bookkeeping.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt_idx <= '0;
      ptr     <= IW'(N_MASTERS - 1);
      outst   <= '0;
      qcnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx <= pick;
            outst   <= '0;
            qcnt    <= '0;
          end
        end
        OWN: begin
          if (nstate == IDLE) begin
            ptr   <= gnt_idx;
            outst <= '0;
          end else begin
            outst <= outst_nxt;
            if (quota_hit && !contend) begin
              qcnt <= '0;
            end else if (s_ack && !qcnt_full) begin
              qcnt <= qcnt + QW'(1);
            end
          end
        end
        DRAIN: begin
          outst <= outst_nxt;
          if (nstate == IDLE) ptr <= gnt_idx;
        end
        default: begin
          outst <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Bench for wshb_rr_arbiter: master/slave models
// with an in-order ack scoreboard.
module tb_wshb_rr_arbiter;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int Q  = 4;
  localparam int MO = 3;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst = 1'b1;
  logic [N-1:0]           m_cyc = '0;
  logic [N-1:0]           m_stb = '0;
  logic [N-1:0]           m_we = '0;
  logic [N-1:0][AW-1:0]   m_adr = '0;
  logic [N-1:0][DW-1:0]   m_dat_w = '0;
  logic [N-1:0][DB-1:0]   m_sel = '0;
  logic [N-1:0]           m_ack;
  logic [N-1:0]           m_stall;
  logic [DW-1:0]          m_dat_r;
  logic                   s_cyc;
  logic                   s_stb;
  logic                   s_we;
  logic [AW-1:0]          s_adr;
  logic [DW-1:0]          s_dat_w;
  logic [DB-1:0]          s_sel;
  logic                   s_ack = 1'b0;
  logic                   s_stall = 1'b0;
  logic [DW-1:0]          s_dat_r = '0;
  logic [1:0]             gnt_idx;
  logic                   busy;

  wshb_rr_arbiter #(
    .N_MASTERS(N), .DATA_BYTES(DB), .ADDR_WIDTH(AW),
    .QUOTA(Q), .MAX_OUTST(MO)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_ack(m_ack), .m_stall(m_stall), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_ack(s_ack), .s_stall(s_stall), .s_dat_r(s_dat_r),
    .gnt_idx(gnt_idx), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int due; logic [DW-1:0] dat; } slv_t;
  typedef struct { int idx; logic [DW-1:0] dat; } exp_t;

  slv_t slq[$];
  exp_t sb[$];
  int   glog[$];
  int   idle_len[$];

  int total[N], issued[N], outs[N], acks[N];
  int first_ack[N], last_ack[N];
  bit en[N], wr[N];
  int lat = 2;
  bit stall_en = 0;
  int cyc_n = 0;
  int tbase = 0;
  int max_pend, cyc_rise, first_scyc, last_fall;
  bit busy_q = 0;
  bit qmode = 0;
  bit drained;
  int t1_acks;
  int errors = 0;
  int checks = 0;
  int rr_exp[6] = '{0, 1, 2, 0, 1, 2};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a,
      input logic [31:0] d, input logic w, input logic [3:0] s);
    return a ^ d ^ {27'd0, w, s};
  endfunction

  function automatic logic [31:0] madr(input int i, input int k);
    return 32'h1000_0000 + tbase + (i << 20) + (k << 2);
  endfunction

  function automatic logic [31:0] mdat(input int i, input int k);
    return 32'hD000_0000 ^ (i << 24) ^ (k * 32'h0101) ^ tbase;
  endfunction

  function automatic logic [3:0] msel(input int k);
    return 4'((k % 15) + 1);
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (issued[i] < total[i] || outs[i] != 0) return 0;
    return 1;
  endfunction

  task automatic clear_logs();
    glog.delete();
    idle_len.delete();
    max_pend   = 0;
    cyc_rise   = -1;
    first_scyc = -1;
    last_fall  = cyc_n;
    drained    = 0;
    t1_acks    = 0;
    for (int i = 0; i < N; i++) begin
      acks[i] = 0; first_ack[i] = -1; last_ack[i] = -1;
    end
  endtask

  task automatic arm(input int i, input int n, input bit w, input bit e);
    total[i] = n; issued[i] = 0; outs[i] = 0;
    wr[i] = w; en[i] = e;
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) arm(i, 0, 0, 0);
    slq.delete();
    sb.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_cyc[i]   = en[i] && (issued[i] < total[i] || outs[i] > 0);
      m_stb[i]   = en[i] && (issued[i] < total[i]);
      m_we[i]    = wr[i];
      m_adr[i]   = madr(i, issued[i]);
      m_dat_w[i] = mdat(i, issued[i]);
      m_sel[i]   = msel(issued[i]);
    end
    if (|m_cyc && cyc_rise < 0) cyc_rise = cyc_n;
    s_stall = stall_en && ($urandom_range(0, 2) == 0);
    if (slq.size() > 0 && slq[0].due <= cyc_n) begin
      s_ack   = 1'b1;
      s_dat_r = slq[0].dat;
    end else begin
      s_ack   = 1'b0;
      s_dat_r = '0;
    end
  endtask

  task automatic observe();
    int   pend;
    exp_t e;
    pend = slq.size();
    if (pend > max_pend) max_pend = pend;
    if (busy && pend == MO) chk("cap_stall", m_stall[gnt_idx], 1);
    if (s_cyc && first_scyc < 0) first_scyc = cyc_n;
    if (busy && !busy_q) begin
      glog.push_back(int'(gnt_idx));
      idle_len.push_back(cyc_n - last_fall);
    end
    if (!busy && busy_q) last_fall = cyc_n;
    busy_q = busy;
    if (qmode && busy && gnt_idx == 0 && glog.size() == 1) begin
      if (m_ack[0]) t1_acks++;
      if (!s_stb) drained = 1;
      if (drained) begin
        chk("drain_stb", s_stb, 0);
        chk("drain_stall", m_stall[0], 1);
      end
    end
    if (s_ack && slq.size() > 0) void'(slq.pop_front());
    if (s_stb && !s_stall)
      slq.push_back('{due: cyc_n + lat,
                      dat: resp(s_adr, s_dat_w, s_we, s_sel)});
    for (int i = 0; i < N; i++) begin
      if (m_stb[i] && !m_stall[i]) begin
        sb.push_back('{idx: i,
          dat: resp(m_adr[i], m_dat_w[i], m_we[i], m_sel[i])});
        issued[i]++;
        outs[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", i, 99);
        end else begin
          e = sb.pop_front();
          chk("ack_idx", i, e.idx);
          chk("ack_dat", m_dat_r, e.dat);
        end
        acks[i]++;
        if (outs[i] > 0) outs[i]--;
        if (first_ack[i] < 0) first_ack[i] = cyc_n;
        last_ack[i] = cyc_n;
      end
    end
    if (qmode && acks[0] >= 2 && !en[1]) en[1] = 1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc_n++;
    drive();
    @(negedge sys_clk);
    observe();
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, all_done(), 1);
    repeat (4) tick();
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drop_all();
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
  endtask

  initial begin
    drop_all();
    clear_logs();
    repeat (2) tick();
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_mstall", m_stall, 3'b111);
    chk("rst_mack", m_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_idx, 0);
    sys_rst = 1'b0;
    tick();

    // single master: m1, 8 reads, latency 2
    clear_logs();
    tbase = 32'h100; lat = 2; stall_en = 0;
    arm(1, 8, 0, 1);
    run("single", 200);
    chk("single_scyc_lat", first_scyc - cyc_rise, 1);
    chk("single_acks1", acks[1], 8);
    chk("single_acks_other", acks[0] + acks[2], 0);
    chk("single_ntenure", glog.size(), 1);
    chk("single_gnt", glog.size() > 0 ? glog[0] : -1, 1);

    // round robin: one write each, twice, with slave stalls
    do_reset();
    clear_logs();
    tbase = 32'h200; lat = 2; stall_en = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) arm(i, 1, 1, 1);
      run("rr", 300);
    end
    stall_en = 0;
    chk("rr_ntenure", glog.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < glog.size()) chk("rr_order", glog[k], rr_exp[k]);
    for (int k = 1; k < 6; k++)
      if (k != 3 && k < idle_len.size())
        chk("rr_gap", idle_len[k], 1);

    // quota hand-over: m0 streams, m1 joins at 2nd ack
    clear_logs();
    tbase = 32'h300; lat = 2; qmode = 1;
    arm(0, 12, 0, 1);
    arm(1, 2, 1, 0);
    run("quota", 400);
    qmode = 0;
    chk("quota_ntenure", glog.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < glog.size()) chk("quota_order", glog[k], (k == 1) ? 1 : 0);
    chk("quota_drain_seen", drained, 1);
    chk("quota_min_acks", t1_acks >= Q, 1);
    chk("quota_max_acks", t1_acks <= Q + MO, 1);
    chk("quota_acks0", acks[0], 12);
    chk("quota_acks1", acks[1], 2);

    // quota without contention: 20 reads, no gaps
    clear_logs();
    tbase = 32'h400; lat = 2;
    arm(0, 20, 0, 1);
    run("noctn", 300);
    chk("noctn_ntenure", glog.size(), 1);
    chk("noctn_acks", acks[0], 20);
    chk("noctn_span", last_ack[0] - first_ack[0], 19);

    // outstanding cap with latency 5
    clear_logs();
    tbase = 32'h500; lat = 5;
    arm(2, 10, 0, 1);
    run("cap", 400);
    chk("cap_max_pend", max_pend, MO);
    chk("cap_acks", acks[2], 10);

    // async reset with outst at 3
    clear_logs();
    tbase = 32'h600; lat = 5;
    arm(0, 10, 0, 1);
    for (int n = 0; n < 60 && slq.size() != 3; n++) tick();
    chk("arst_setup_outst", slq.size(), 3);
    chk("arst_pre_scyc", s_cyc, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_scyc", s_cyc, 0);
    chk("arst_mstall", m_stall, 3'b111);
    chk("arst_busy", busy, 0);
    chk("arst_mack", m_ack, 0);
    drop_all();
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    clear_logs();
    tbase = 32'h700; lat = 2;
    arm(2, 1, 0, 1);
    arm(0, 1, 0, 1);
    run("arst_after", 200);
    chk("arst_ntenure", glog.size(), 2);
    chk("arst_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("arst_second", glog.size() > 1 ? glog[1] : -1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
